// File: rtl/multi_edge_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_edge_cnt_pkg: shared types for the multi-channel edge counter. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package multi_edge_cnt_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    localparam int MAX_N_CH = 16;

endpackage
`default_nettype wire

// File: rtl/multi_edge_counter_edge_sync_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | edge_sync_detect: synchroniser chain, history flop and edge select   |
// | for one asynchronous input bit.                                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module edge_sync_detect
    import multi_edge_cnt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       async_in,
    input  edge_mode_t edge_mode,
    output logic       edge_strobe
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];
    assign w_rise = w_sync & ~r_hist;
    assign w_fall = ~w_sync & r_hist;

    // Mode select is combinational so a mode change takes effect immediately.
    always_comb begin
        edge_strobe = 1'b0;
        unique case (edge_mode)
            EDGE_RISE: edge_strobe = w_rise;
            EDGE_FALL: edge_strobe = w_fall;
            EDGE_BOTH: edge_strobe = w_rise | w_fall;
            EDGE_OFF:  edge_strobe = 1'b0;
            default:   edge_strobe = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multi_edge_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multi_edge_counter: N-channel saturating/wrapping edge counter.      |
// | Optional snapshot ports enabled by MULTI_EDGE_CNT_SNAPSHOT_EN.        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module multi_edge_counter
    import multi_edge_cnt_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH-1:0]       signal_in,
    input  edge_mode_t            edge_mode,
    input  logic                  sat_mode,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH*CNT_W-1:0] counter_out,
    output logic [N_CH-1:0]       overflow,
    output logic [N_CH-1:0]       event_pulse
`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
    ,
    input  logic                  snap,
    input  logic                  snap_clr,
    output logic [N_CH*CNT_W-1:0] snap_out,
    output logic                  snap_valid
`endif
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic w_snap_clr;

`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
    logic r_snap_valid;

    assign w_snap_clr = snap & snap_clr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_snap_valid <= 1'b0;
        end else if (snap) begin
            r_snap_valid <= 1'b1;
        end
    end

    assign snap_valid = r_snap_valid;
`else
    assign w_snap_clr = 1'b0;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic             w_edge;
        logic             w_at_max;
        logic [CNT_W-1:0] w_cnt_next;
        logic [CNT_W-1:0] r_cnt;
        logic             r_ovf;
        logic             r_evt;

        edge_sync_detect #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_detect (
            .clk         (clk),
            .reset       (reset),
            .async_in    (signal_in[i]),
            .edge_mode   (edge_mode),
            .edge_strobe (w_edge)
        );

        assign w_at_max = (r_cnt == C_CNT_MAX);

        always_comb begin
            w_cnt_next = r_cnt;
            if (w_edge) begin
                if (w_at_max) begin
                    w_cnt_next = sat_mode ? C_CNT_MAX : '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
        end

        // Channel clear outranks everything, including a coincident edge.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_evt <= 1'b0;
            end else if (clr[i]) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
                r_evt <= 1'b0;
            end else begin
                r_cnt <= w_snap_clr ? '0 : w_cnt_next;
                r_ovf <= r_ovf | (w_edge & w_at_max);
                r_evt <= w_edge;
            end
        end

        assign counter_out[i*CNT_W +: CNT_W] = r_cnt;
        assign overflow[i]                   = r_ovf;
        assign event_pulse[i]                = r_evt;

`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
        logic [CNT_W-1:0] r_snap;

        // Captures the value the counter would take this cycle, before snap_clr.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_snap <= '0;
            end else if (snap) begin
                r_snap <= clr[i] ? '0 : w_cnt_next;
            end
        end

        assign snap_out[i*CNT_W +: CNT_W] = r_snap;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_edge_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_multi_edge_counter: directed, table-driven bench for the counter. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_multi_edge_counter;
    import multi_edge_cnt_pkg::*;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;

    logic              clk;
    logic              reset;
    logic [N_CH-1:0]   signal_in;
    edge_mode_t        edge_mode;
    logic              sat_mode;
    logic [N_CH-1:0]   clr;
    logic [31:0]       counter_out;
    logic [N_CH-1:0]   overflow;
    logic [N_CH-1:0]   event_pulse;
`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
    logic              snap;
    logic              snap_clr;
    logic [31:0]       snap_out;
    logic              snap_valid;
`endif

    int errors;
    int checks;
    int ev_cnt;

    multi_edge_counter #(
        .N_CH        (N_CH),
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .signal_in   (signal_in),
        .edge_mode   (edge_mode),
        .sat_mode    (sat_mode),
        .clr         (clr),
        .counter_out (counter_out),
        .overflow    (overflow),
        .event_pulse (event_pulse)
`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
        ,
        .snap        (snap),
        .snap_clr    (snap_clr),
        .snap_out    (snap_out),
        .snap_valid  (snap_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        edge_mode_t  mode;
        logic [3:0]  mask;
        int          pulses;
        int          width;
        bit          rise_only;
        logic [31:0] exp_cnt;
        logic [3:0]  exp_ov;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ev_cnt += int'(event_pulse[0]);
    endtask

    task automatic pulse(input logic [3:0] mask, input int n, input int w, input bit rise_only);
        for (int p = 0; p < n; p++) begin
            signal_in = mask;
            repeat (w) tick();
            if (!rise_only) signal_in = '0;
            repeat (w) tick();
        end
    endtask

    task automatic quiesce_and_clear();
        edge_mode = EDGE_OFF;
        signal_in = '0;
        repeat (4) tick();
        clr = '1;
        tick();
        clr = '0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        ev_cnt    = 0;
        reset     = 1'b1;
        signal_in = '0;
        edge_mode = EDGE_RISE;
        sat_mode  = 1'b1;
        clr       = '0;
`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
        snap      = 1'b0;
        snap_clr  = 1'b0;
`endif

        vecs[0] = '{EDGE_RISE, 4'b0001, 5, 3, 1'b0, 32'h0000_0005, 4'b0000};
        vecs[1] = '{EDGE_BOTH, 4'b0010, 4, 3, 1'b0, 32'h0000_0800, 4'b0000};
        vecs[2] = '{EDGE_OFF,  4'b1111, 3, 2, 1'b0, 32'h0000_0000, 4'b0000};
        vecs[3] = '{EDGE_FALL, 4'b0100, 1, 3, 1'b1, 32'h0000_0000, 4'b0000};
        vecs[4] = '{EDGE_FALL, 4'b1000, 2, 3, 1'b0, 32'h0200_0000, 4'b0000};
        vecs[5] = '{EDGE_BOTH, 4'b1111, 3, 2, 1'b0, 32'h0606_0606, 4'b0000};
        vecs[6] = '{EDGE_RISE, 4'b0101, 7, 1, 1'b0, 32'h0007_0007, 4'b0000};

        // Reset held with inputs toggling: nothing may move.
        for (int c = 0; c < 6; c++) begin
            signal_in = ~signal_in;
            tick();
        end
        check("rst_cnt", 64'(counter_out), 64'h0);
        check("rst_flags", 64'({overflow, event_pulse}), 64'h0);
`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
        check("rst_snap", 64'({snap_valid, snap_out}), 64'h0);
`endif
        signal_in = '0;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("idle_cnt", 64'(counter_out), 64'h0);

        // Latency: first rising edge reaches the counter two clocks after sampling.
        ev_cnt    = 0;
        edge_mode = EDGE_RISE;
        signal_in = 4'b0001;
        tick();
        tick();
        check("lat_before", 64'({event_pulse, counter_out}), 64'h0);
        tick();
        check("lat_cnt", 64'(counter_out), 64'h1);
        check("lat_evt", 64'(event_pulse), 64'h1);
        repeat (3) tick();
        signal_in = '0;
        repeat (3) tick();
        pulse(4'b0001, 4, 3, 1'b0);
        repeat (4) tick();
        check("rise5_cnt", 64'(counter_out), 64'h5);
        check("rise5_evts", 64'(ev_cnt), 64'd5);

        for (int v = 0; v < 7; v++) begin
            quiesce_and_clear();
            edge_mode = vecs[v].mode;
            pulse(vecs[v].mask, vecs[v].pulses, vecs[v].width, vecs[v].rise_only);
            repeat (4) tick();
            check($sformatf("vec%0d_cnt", v), 64'(counter_out), 64'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_ovf", v), 64'(overflow), 64'(vecs[v].exp_ov));
        end

        // Saturation and wrap on 257 edges.
        quiesce_and_clear();
        edge_mode = EDGE_RISE;
        sat_mode  = 1'b1;
        pulse(4'b0001, 257, 1, 1'b0);
        repeat (4) tick();
        check("sat_cnt", 64'(counter_out), 64'h0000_00FF);
        check("sat_ovf", 64'(overflow), 64'h1);
        clr = 4'b0001;
        tick();
        clr = '0;
        check("sat_clr", 64'({overflow, counter_out}), 64'h0);
        sat_mode = 1'b0;
        pulse(4'b0001, 257, 1, 1'b0);
        repeat (4) tick();
        check("wrap_cnt", 64'(counter_out), 64'h0000_0001);
        check("wrap_ovf", 64'(overflow), 64'h1);
        clr = 4'b0001;
        tick();
        clr = '0;
        check("wrap_clr", 64'({overflow, counter_out}), 64'h0);
        sat_mode = 1'b1;

        // Clear on ch2 coincides with edges on ch2 and ch3.
        quiesce_and_clear();
        edge_mode = EDGE_RISE;
        pulse(4'b1100, 3, 2, 1'b0);
        repeat (4) tick();
        check("pre_clr_cnt", 64'(counter_out), 64'h0303_0000);
        signal_in = 4'b1100;
        tick();
        tick();
        clr = 4'b0100;
        tick();
        clr = '0;
        check("clr_coinc_cnt", 64'(counter_out), 64'h0400_0000);
        check("clr_coinc_evt", 64'(event_pulse), 64'b1000);
        signal_in = '0;
        repeat (4) tick();

`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
        quiesce_and_clear();
        edge_mode = EDGE_RISE;
        pulse(4'b0001, 10, 1, 1'b0);
        repeat (4) tick();
        check("snap_pre_cnt", 64'(counter_out), 64'h0A);
        signal_in = 4'b0001;
        tick();
        tick();
        snap     = 1'b1;
        snap_clr = 1'b1;
        tick();
        snap     = 1'b0;
        snap_clr = 1'b0;
        check("snap_out", 64'(snap_out), 64'h0B);
        check("snap_cnt", 64'(counter_out), 64'h0);
        check("snap_valid", 64'(snap_valid), 64'h1);
        signal_in = '0;
        repeat (4) tick();
`endif

        // Asynchronous reset mid-count, input held high through release.
        edge_mode = EDGE_RISE;
        pulse(4'b0001, 3, 1, 1'b0);
        signal_in = 4'b0001;
        tick();
        reset = 1'b1;
        #2;
        check("async_rst_cnt", 64'(counter_out), 64'h0);
        check("async_rst_flags", 64'({overflow, event_pulse}), 64'h0);
`ifdef MULTI_EDGE_CNT_SNAPSHOT_EN
        check("async_rst_snap", 64'({snap_valid, snap_out}), 64'h0);
`endif
        tick();
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rel_high_before", 64'(counter_out), 64'h0);
        tick();
        check("rel_high_cnt", 64'(counter_out), 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
